piso_shift_out: RTL and testbench

PISO_SHIFT_OUT -- requirements
Module: piso_shift_out

---
 rtl/piso_pkg.sv | 20 ++
 rtl/piso_bit_counter.sv | 31 +++
 rtl/piso_shift_out.sv | 136 +++++++++++++
 tb/tb_piso_shift_out.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in serial-out shifter.
// The PARITY state only exists when PISO_PARITY_EN is defined.
package piso_pkg;

  localparam int PISO_DEFAULT_WIDTH = 4;

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } piso_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } piso_state_t;
`endif

endpackage

// File: rtl/piso_bit_counter.sv
// Counts data bits taken from the shifter; o_tc flags the final data bit.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_tc
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] r_cnt;

  // Clear wins over increment so a back-to-back load restarts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_shift_out.sv
// Parallel-in serial-out shifter with valid/ready on both sides.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
//
// Handshake: a transfer happens on a rising edge where valid=1 and ready=1.
// load side: load_valid/load_ready; serial side: so_valid/so_ready.
// While so_valid=1 and so_ready=0, so/so_valid/so_last are held.
module piso_shift_out
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pi,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             so,
  output logic             so_valid,
  input  logic             so_ready,
  output logic             so_last,
  output logic             busy,
  output piso_state_t      dbg_state
);

  piso_state_t      r_state;
  piso_state_t      w_next;
  logic [WIDTH-1:0] r_sr;
  logic             w_accept;
  logic             w_shift_take;
  logic             w_tc;
  logic             w_data_bit;
`ifdef PISO_PARITY_EN
  logic             r_par;
`endif

  assign w_data_bit   = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];
  assign w_shift_take = (r_state == ST_SHIFT) && so_ready;

  // Ready in IDLE, or on the edge that retires the final frame bit.
  assign load_ready = !rst && ((r_state == ST_IDLE) || (so_valid && so_ready && so_last));
  assign w_accept   = load_valid && load_ready;
  assign dbg_state  = r_state;

  piso_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_accept),
    .i_inc  (w_shift_take),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= '0;
`ifdef PISO_PARITY_EN
      r_par <= 1'b0;
`endif
    end else if (w_accept) begin
      r_sr <= pi;
`ifdef PISO_PARITY_EN
      r_par <= ^pi;
`endif
    end else if (w_shift_take) begin
      r_sr <= MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
    end
  end

  // Serial outputs are decoded from registered state only.
  always_comb begin
    so       = 1'b0;
    so_valid = 1'b0;
    so_last  = 1'b0;
    busy     = 1'b0;
    case (r_state)
      ST_SHIFT: begin
        so_valid = 1'b1;
        busy     = 1'b1;
        so       = w_data_bit;
`ifdef PISO_PARITY_EN
        so_last  = 1'b0;
`else
        so_last  = w_tc;
`endif
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        so_valid = 1'b1;
        busy     = 1'b1;
        so       = r_par;
        so_last  = 1'b1;
      end
`endif
      default: begin
        so_valid = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (so_ready && w_tc) begin
`ifdef PISO_PARITY_EN
          w_next = ST_PARITY;
`else
          w_next = w_accept ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        if (so_ready) w_next = w_accept ? ST_SHIFT : ST_IDLE;
      end
`endif
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_shift_out.sv
// Self-checking bench for piso_shift_out (WIDTH=4, MSB first).
// Builds with or without PISO_PARITY_EN.
module tb_piso_shift_out;
  import piso_pkg::*;

`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  pi;
  logic        load_valid;
  logic        load_ready;
  logic        so;
  logic        so_valid;
  logic        so_ready;
  logic        so_last;
  logic        busy;
  piso_state_t dbg_state;

  int checks;
  int failures;

  // Expected serial bits in order: {last, bit}.
  logic [1:0]  exp_q[$];
  logic [31:0] cap;
  int          ncap;

  piso_shift_out #(
    .WIDTH    (4),
    .MSB_FIRST(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pi        (pi),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .so        (so),
    .so_valid  (so_valid),
    .so_ready  (so_ready),
    .so_last   (so_last),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A frame is the word MSB first, optionally followed by its XOR parity.
  task automatic push_frame(input logic [3:0] w);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({(i == 3) && !PAR, w[3-i]});
    end
    if (PAR) exp_q.push_back({1'b1, ^w});
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, advance model.
  task automatic cyc(input logic lv, input logic [3:0] w, input logic sr);
    logic ev;
    logic elr;
    @(negedge clk);
    load_valid = lv;
    pi         = w;
    so_ready   = sr;
    #1;
    ev = (exp_q.size() != 0);
    check("so_valid", so_valid, ev);
    check("busy", busy, ev);
    if (ev) begin
      check("so", so, exp_q[0][0]);
      check("so_last", so_last, exp_q[0][1]);
    end else begin
      check("so_idle_zero", so, 1'b0);
    end
    elr = !ev || (sr && exp_q[0][1]);
    check("load_ready", load_ready, elr);
    if (ev && sr) begin
      cap = {cap[30:0], so};
      ncap++;
      void'(exp_q.pop_front());
    end
    if (lv && elr) push_frame(w);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      cyc(1'b0, 4'($urandom_range(0, 15)), 1'b1);
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'd0, 32'd1);
    cyc(1'b0, 4'd0, 1'b1);
  endtask

  task automatic clear_cap();
    cap  = '0;
    ncap = 0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    pi         = 4'd0;
    load_valid = 1'b0;
    so_ready   = 1'b1;
    clear_cap();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_so_valid", so_valid, 1'b0);
    check("rst_so", so, 1'b0);
    check("rst_so_last", so_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_load_ready", load_ready, 1'b0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_load_ready", load_ready, 1'b1);

    // Single frame 1101
    clear_cap();
    cyc(1'b1, 4'b1101, 1'b1);
    drain();
    check("frame1_len", ncap, PAR ? 5 : 4);
    check("frame1_bits", cap, PAR ? 32'b11011 : 32'b1101);

    // Stall for 3 cycles while the 2nd bit is presented
    clear_cap();
    cyc(1'b1, 4'b1101, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1);
    repeat (3) cyc(1'b0, 4'b0110, 1'b0);
    drain();
    check("stall_bits", cap, PAR ? 32'b11011 : 32'b1101);

    // Back-to-back frames with no gap
    clear_cap();
    cyc(1'b1, 4'b1101, 1'b1);
    repeat (PAR ? 5 : 4) cyc(1'b1, 4'b1000, 1'b1);
    drain();
    check("b2b_len", ncap, PAR ? 10 : 8);
    check("b2b_bits", cap, PAR ? 32'b1101110001 : 32'b11011000);

    // Reset after 2 bits drops the frame
    clear_cap();
    cyc(1'b1, 4'b1101, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1);
    @(negedge clk);
    load_valid = 1'b0;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("midrst_so_valid", so_valid, 1'b0);
    check("midrst_so", so, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_load_ready", load_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_rel_ready", load_ready, 1'b1);
    repeat (4) cyc(1'b0, 4'b1111, 1'b1);
    check("midrst_bits", ncap, 2);

    // Load pulse mid-frame is ignored
    clear_cap();
    cyc(1'b1, 4'b1101, 1'b1);
    cyc(1'b1, 4'b0000, 1'b1);
    drain();
    check("ignore_bits", cap, PAR ? 32'b11011 : 32'b1101);
    check("ignore_len", ncap, PAR ? 5 : 4);

    // Randomised traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
